// File: rtl/axi4_master_bridge.sv
// Single-outstanding AXI4 master: turns a valid/ready memory request into one AR/R burst or one AW/W/B write.
// Optional response checker (rid/bid/rlast) is enabled by defining AXI4_MASTER_RCHK_EN.
module axi4_master_bridge #(
  parameter logic [3:0] AXI_ID     = 4'h0,
  parameter logic       WRAP_BURST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_len,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_last,
  output logic        resp_err,
  output logic        io_master_awvalid,
  input  logic        io_master_awready,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  output logic        io_master_wvalid,
  input  logic        io_master_wready,
  output logic [31:0] io_master_wdata,
  output logic [3:0]  io_master_wstrb,
  output logic        io_master_wlast,
  input  logic        io_master_bvalid,
  output logic        io_master_bready,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  output logic        io_master_arvalid,
  input  logic        io_master_arready,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  input  logic        io_master_rvalid,
  output logic        io_master_rready,
  input  logic [1:0]  io_master_rresp,
  input  logic [31:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_len;
  logic [7:0]  r_beat_cnt;
  logic [2:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_arburst;
  logic        r_arvalid;
  logic        r_awvalid;
  logic        r_wvalid;

  logic w_wrap_len;
  logic w_last_beat;
  logic w_r_hs;
  logic w_b_hs;
  logic w_aw_done;
  logic w_w_done;
  logic w_fault;

  // WRAP is only legal for 2/4/8/16 beats; anything else falls back to INCR.
  assign w_wrap_len  = WRAP_BURST && ((req_len == 8'd1) || (req_len == 8'd3) ||
                                      (req_len == 8'd7) || (req_len == 8'd15));
  assign w_last_beat = (r_beat_cnt == 8'd0);
  assign w_r_hs      = (r_state == S_R) && io_master_rvalid && resp_ready;
  assign w_b_hs      = (r_state == S_B) && io_master_bvalid && resp_ready;
  assign w_aw_done   = !r_awvalid || io_master_awready;
  assign w_w_done    = !r_wvalid || io_master_wready;

`ifdef AXI4_MASTER_RCHK_EN
  logic r_chk_fault;

  assign w_fault = ((r_state == S_R) && io_master_rvalid &&
                    ((io_master_rid != AXI_ID) || (io_master_rlast != w_last_beat))) ||
                   ((r_state == S_B) && io_master_bvalid && (io_master_bid != AXI_ID));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_chk_fault <= 1'b0;
    else        r_chk_fault <= r_chk_fault | w_fault;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset && w_fault) $error("axi4_master_bridge: response id/rlast fault");
  end
`endif
`else
  logic w_unused_chk;
  assign w_fault      = 1'b0;
  assign w_unused_chk = ^{io_master_rid, io_master_bid, io_master_rlast};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_len      <= 8'd0;
      r_beat_cnt <= 8'd0;
      r_size     <= 3'd0;
      r_wstrb    <= 4'd0;
      r_arburst  <= 2'd0;
      r_arvalid  <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr    <= req_addr;
            r_size    <= req_size;
            r_len     <= req_len;
            r_wdata   <= req_wdata;
            r_wstrb   <= req_wstrb;
            r_arburst <= w_wrap_len ? 2'b10 : 2'b01;
            if (req_wen) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_AW_W;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (io_master_arready) begin
            r_arvalid  <= 1'b0;
            r_beat_cnt <= r_len;
            r_state    <= S_R;
          end
        end
        S_R: begin
          // Our own beat counter ends the burst; rlast is only consulted by the checker.
          if (w_r_hs) begin
            if (w_last_beat) r_state <= S_IDLE;
            else             r_beat_cnt <= r_beat_cnt - 8'd1;
          end
        end
        S_AW_W: begin
          if (io_master_awready) r_awvalid <= 1'b0;
          if (io_master_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) r_state <= S_B;
        end
        S_B: begin
          if (w_b_hs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready         = (r_state == S_IDLE);
  assign o_dbg_state       = r_state;

  assign io_master_arvalid = r_arvalid;
  assign io_master_araddr  = r_addr;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = r_len;
  assign io_master_arsize  = r_size;
  assign io_master_arburst = r_arburst;

  assign io_master_awvalid = r_awvalid;
  assign io_master_awaddr  = r_addr;
  assign io_master_awid    = AXI_ID;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = r_size;
  assign io_master_awburst = 2'b01;

  assign io_master_wvalid  = r_wvalid;
  assign io_master_wdata   = r_wdata;
  assign io_master_wstrb   = r_wstrb;
  assign io_master_wlast   = 1'b1;

  // Handshake: a beat moves when valid and ready are both high at a rising clock edge;
  // the response side has no buffering, so resp_ready is passed straight to rready/bready.
  assign io_master_rready  = (r_state == S_R) && resp_ready;
  assign io_master_bready  = (r_state == S_B) && resp_ready;

  always_comb begin
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_last  = 1'b0;
    resp_err   = 1'b0;
    case (r_state)
      S_R: begin
        resp_valid = io_master_rvalid;
        resp_rdata = io_master_rdata;
        resp_last  = w_last_beat;
        resp_err   = (io_master_rresp != 2'b00) || w_fault;
      end
      S_B: begin
        resp_valid = io_master_bvalid;
        resp_last  = 1'b1;
        resp_err   = (io_master_bresp != 2'b00) || w_fault;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Directed bench for axi4_master_bridge: bench-side AXI responder plus a response scoreboard.
// Define AXI4_MASTER_RCHK_EN in both builds to exercise the response checker.
module tb_axi4_master_bridge;

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [7:0]  req_len;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_last, resp_err;
  logic [31:0] resp_rdata;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, dbg_state;
  logic [1:0]  awburst, bresp, arburst, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];

  axi4_master_bridge #(.AXI_ID(4'h0), .WRAP_BURST(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_last(resp_last), .resp_err(resp_err),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp),
    .io_master_bid(bid),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rresp(rresp),
    .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid),
    .o_dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: any response handshake visible on the falling edge completes on the next rising edge.
  always @(negedge clock) begin
    if (reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL resp_unexpected: observed %h expected none", {resp_last, resp_err, resp_rdata});
      end else begin
        chk("resp_beat", {resp_last, resp_err, resp_rdata}, exp_q.pop_front());
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] exp_burst, input logic [31:0] base,
                         input logic [15:0] rdy_pat, input int err_beat, input int bad_last);
    int beat, cyc, stalls;
    logic e;
    for (int i = 0; i <= int'(len); i++) begin
      e = (i == err_beat);
`ifdef AXI4_MASTER_RCHK_EN
      e = e | (i == bad_last);
`endif
      exp_q.push_back({(i == int'(len)), e, base + 32'(i)});
    end
    step();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = addr; req_len = len; req_size = size;
    req_wdata = $urandom; req_wstrb = 4'($urandom_range(0, 15));
    @(negedge clock);
    chk("rd_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0; arready = 1'b1;
    @(negedge clock);
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, addr);
    chk("arlen", arlen, len);
    chk("arsize", arsize, size);
    chk("arburst", arburst, exp_burst);
    chk("arid", arid, 0);
    chk("rd_req_ready_busy", req_ready, 0);
    step();
    arready = 1'b0;
    beat = 0; cyc = 0; stalls = 0;
    while (beat <= int'(len) && cyc < 200) begin
      rvalid = 1'b1;
      rdata  = base + 32'(beat);
      rresp  = (beat == err_beat) ? 2'b11 : 2'b00;
      rlast  = (beat == int'(len)) ^ (beat == bad_last);
      rid    = 4'h0;
      resp_ready = (cyc < 16) ? rdy_pat[cyc] : 1'b1;
      if (!resp_ready) stalls++;
      @(negedge clock);
      chk("rready_mirror", rready, resp_ready);
      if (cyc == 0) chk("arvalid_dropped", arvalid, 0);
      if (resp_ready) beat++;
      cyc++;
      step();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; resp_ready = 1'b1;
    chk("rd_beats", beat, int'(len) + 1);
    chk("rd_rate", cyc, int'(len) + 1 + stalls);
    @(negedge clock);
    chk("rd_req_ready_after", req_ready, 1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] size, input int aw_dly, input int w_dly,
                          input logic [1:0] bresp_v);
    logic exp_aw, exp_w;
    int cyc;
    exp_q.push_back({1'b1, (bresp_v != 2'b00), 32'h0});
    step();
    req_valid = 1'b1; req_wen = 1'b1; req_addr = addr; req_wdata = data; req_wstrb = strb;
    req_size = size; req_len = 8'($urandom_range(0, 255));
    @(negedge clock);
    chk("wr_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    exp_aw = 1'b1; exp_w = 1'b1; cyc = 0;
    while ((exp_aw || exp_w) && cyc < 50) begin
      awready = (cyc >= aw_dly);
      wready  = (cyc >= w_dly);
      @(negedge clock);
      chk("awvalid", awvalid, exp_aw);
      chk("wvalid", wvalid, exp_w);
      if (exp_aw) begin
        chk("awaddr", awaddr, addr);
        chk("aw_len_burst_size_id", {awlen, awburst, awsize, awid}, {8'd0, 2'b01, size, 4'h0});
      end
      if (exp_w) chk("w_data_strb_last", {wdata, wstrb, wlast}, {data, strb, 1'b1});
      if (awready) exp_aw = 1'b0;
      if (wready)  exp_w  = 1'b0;
      cyc++;
      step();
    end
    awready = 1'b0; wready = 1'b0;
    chk("aw_w_done", {exp_aw, exp_w}, 0);
    bvalid = 1'b1; bresp = bresp_v; bid = 4'h0; resp_ready = 1'b0;
    @(negedge clock);
    chk("b_state", dbg_state, 3'd4);
    chk("bready_stall", bready, 0);
    chk("b_resp_view", {resp_valid, resp_last, resp_err}, {1'b1, 1'b1, (bresp_v != 2'b00)});
    step();
    resp_ready = 1'b1;
    @(negedge clock);
    chk("bready", bready, 1);
    step();
    bvalid = 1'b0; bresp = 2'b00;
    @(negedge clock);
    chk("wr_req_ready_after", req_ready, 1);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_len = 0; req_wdata = 0; req_wstrb = 0;
    resp_ready = 1'b1;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0; rlast = 0; rid = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_last, resp_err}, 0);
    chk("rst_regs", {araddr, awaddr, wdata}, 0);
    chk("rst_state", dbg_state, 3'd0);
    step();
    reset = 1'b1;

    // Single read, WRAP with stalls, illegal wrap lengths, zero-wait 8-beat WRAP
    do_read(32'h8000_0004, 8'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, 16'hFFFF, -1, -1);
    do_read(32'h8000_0008, 8'd3, 3'd2, 2'b10, $urandom, 16'hFFFD, -1, -1);
    do_read(32'h8000_0010, 8'd2, 3'd2, 2'b01, $urandom, 16'hFFFF, -1, -1);
    do_read(32'h8000_0020, 8'd7, 3'd2, 2'b10, $urandom, 16'hFFFF, -1, -1);
    do_read(32'h8000_0040, 8'd4, 3'd1, 2'b01, $urandom, 16'hFFF6, -1, -1);

    // Writes: late AW, simultaneous AW/W with error, late W
    do_write(32'hA000_03F8, 32'h0000_0041, 4'b0001, 3'd0, 3, 0, 2'b00);
    do_write(32'hA000_0100, $urandom, 4'b1111, 3'd2, 0, 0, 2'b10);
    do_write(32'hA000_0200, $urandom, 4'b1100, 3'd1, 0, 2, 2'b00);

    // Read error on the second beat of four
    do_read(32'h8000_0080, 8'd3, 3'd2, 2'b10, $urandom, 16'hFFFF, 1, -1);

    // Asynchronous reset while in R with a beat on the bus
    step();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_1000; req_len = 8'd3; req_size = 3'd2;
    step();
    req_valid = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; rlast = 1'b0; resp_ready = 1'b1;
    #1;
    chk("pre_rst_state", dbg_state, 3'd2);
    chk("pre_rst_rready", rready, 1);
    reset = 1'b0;
    #1;
    chk("async_rst_req_ready", req_ready, 1);
    chk("async_rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 0);
    chk("async_rst_araddr", araddr, 0);
    rvalid = 1'b0;
    step();
    reset = 1'b1;

    // Recovery after reset
    do_read(32'h8000_2000, 8'd1, 3'd2, 2'b10, $urandom, 16'hFFFF, -1, -1);

`ifdef AXI4_MASTER_RCHK_EN
    do_read(32'h8000_3000, 8'd3, 3'd2, 2'b10, $urandom, 16'hFFFF, -1, 0);
    chk("chk_fault", dut.r_chk_fault, 1);
`endif

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi4_master_bridge.md
Name: axi4_master_bridge

Overview:
- Single-outstanding AXI4 master. Converts the core's simple valid/ready memory request port into AXI4 transactions on the io_master bus.
- Reads may be single-beat or bursts, used for I-cache line fill. Writes are always single-beat.
- Sits between the LSU/ICache arbiter and the top-level io_master_* ports. It is the initiator side that the memory/peripheral responder answers.

Parameters:
- AXI_ID, 4'h0, value driven on awid/arid; expected on rid/bid.
- WRAP_BURST, 1, 1: multi-beat reads use WRAP burst; 0: INCR.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid/req_ready  in/out  1/1  request handshake
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_size  in  3  AXI size code, 0..2
- req_len  in  8  read beats minus 1; ignored for writes
- req_wdata/req_wstrb  in  32/4  write data and strobes
- resp_valid/resp_ready  out/in  1/1  response handshake
- resp_rdata  out  32  read beat data
- resp_last  out  1  final beat of the response
- resp_err  out  1  rresp/bresp != 0, or a checker fault
- io_master_aw*, w*, b*, ar*, r*  (AXI4 master side) awvalid/awready, awaddr 32, awid 4, awlen 8, awsize 3, awburst 2; wvalid/wready, wdata 32, wstrb 4, wlast; bvalid/bready, bresp 2, bid 4; arvalid/arready, araddr 32, arid 4, arlen 8, arsize 3, arburst 2; rvalid/rready, rresp 2, rdata 32, rlast, rid 4

Behaviour:
- Reset values:
  - State = IDLE.
  - req_ready = 1.
  - arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_last, resp_err = 0.
  - All address/data registers = 0.
- Reset mid-transaction returns to IDLE immediately. No cleanup of the AXI bus is attempted.
- FSM states: IDLE, AR, R, AW_W, B.
- IDLE:
  - req_ready = 1 only in IDLE.
  - On req_valid & req_ready, the request is registered. Next cycle: AR if req_wen = 0, else AW_W.
  - Latency: acceptance in cycle N gives arvalid, or awvalid + wvalid, high in cycle N+1.
- AR:
  - araddr = req_addr; arlen = req_len; arsize = req_size; arid = AXI_ID.
  - arburst = 2'b01 (INCR) if req_len = 0 or WRAP_BURST = 0.
  - arburst = 2'b10 (WRAP) if WRAP_BURST = 1 and req_len is in {1, 3, 7, 15}.
  - Any other req_len forces INCR.
  - arvalid is held with stable payload until arready. Then go to R, loading beat_cnt = req_len.
- R:
  - rready = resp_ready, combinational pass-through.
  - resp_valid = rvalid; resp_rdata = rdata; resp_err = (rresp != 0).
  - resp_last = (beat_cnt == 0).
  - On each rvalid & rready: beat_cnt decrements. When the beat had beat_cnt = 0, go to IDLE.
  - The internal counter, not rlast, terminates the burst.
- AW_W:
  - awvalid and wvalid rise together. Each drops independently on its own handshake.
  - awlen = 0; awburst = INCR; awsize = req_size; wlast = 1; wstrb = req_wstrb (unmodified); wdata = req_wdata.
  - Simultaneous AW and W handshakes in one cycle are legal.
  - Go to B once both handshakes have occurred, whether in the same cycle or in different cycles.
- B:
  - bready = resp_ready; resp_valid = bvalid; resp_last = 1; resp_err = (bresp != 0); resp_rdata = 0.
  - On handshake, go to IDLE.
- Zero-wait responder (arready = 1 and rvalid on the next cycle) must sustain 1 beat/cycle while resp_ready = 1.
- resp_ready = 0 stalls the bus through rready/bready. No internal buffering.

Optional Feature:
- Macro: AXI4_MASTER_RCHK_EN.
- With the macro, in R and B, a fault is flagged when either of these holds:
  - rid/bid != AXI_ID;
  - rlast != (beat_cnt == 0).
- On a fault: resp_err is forced to 1 for that beat, a sticky chk_fault flag (internal, reset 0) is set, and $error is issued in simulation.
- Without the macro, rid, bid and rlast are ignored entirely. resp_err reflects rresp/bresp only.

Test Plan:
- Single read:
  - Stimulus: req addr 0x8000_0004, len 0, size 2; responder returns 0xDEADBEEF, rresp 0.
  - Required: araddr 0x8000_0004, arlen 0, arburst 01, arvalid one cycle after acceptance; one resp beat 0xDEADBEEF with last = 1; req_ready back to 1 the cycle after.
- WRAP burst:
  - Stimulus: addr 0x8000_0008, len 3, WRAP_BURST = 1; resp_ready toggles 1,0,1,1,1.
  - Required: arburst 10; 4 beats delivered in order; resp_last only on the 4th; rready mirrors resp_ready each cycle.
- Illegal wrap length:
  - Stimulus: len 2.
  - Required: arburst 01 (INCR); 3 beats delivered.
- Write ordering:
  - Stimulus: addr 0xA000_03F8, wdata 0x41, wstrb 4'b0001; awready delayed 3 cycles, wready immediate.
  - Required: wvalid drops after 1 cycle; awvalid holds until awready; B state then resp_valid with last = 1, err = 0.
- Error response:
  - Stimulus: bresp 2'b10 on a write; rresp 2'b11 on beat 2 of a 4-beat read.
  - Required: resp_err = 1 on exactly those beats.
- Reset and checker:
  - Stimulus: reset = 0 while in R.
  - Required: all valids 0 and req_ready = 1 asynchronously.
  - Stimulus (RCHK_EN): rlast asserted on beat 1 of 4.
  - Required: resp_err = 1 on that beat; chk_fault = 1.
